// File: rtl/viterbi_lr_scorer.sv
// viterbi_lr_scorer: left-to-right HMM Viterbi word-spotting scorer.
//
// Each frame updates STATES log-domain path scores (delta) from a double-buffered
// observation set and a runtime-loadable transition table. It also tracks each state's
// path duration. A detection is flagged when the final-state score reaches THRESH times
// its duration.
//
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   obs_we_i         write obs_data_i into observation buffer slot obs_addr_i
//   trans_we_i       write trans_data_i to a(j,j) (trans_sel_i=0) or a(j-1,j) (=1), j=trans_addr_i
//   frame_valid_i    observation buffer complete; start a frame (idle only)
//   clear_i          restart the search (idle only, wins over frame_valid_i)
//   busy_o           frame in progress
//   dv_o             one-cycle result strobe; detect_o/score_o/duration_o valid with it
//   overrun_o        sticky: frame_valid_i seen while busy
module viterbi_lr_scorer #(
    parameter int unsigned STATES  = 5,
    parameter int unsigned OBS_W   = 32,
    parameter int unsigned TRANS_W = 16,
    parameter int unsigned SCORE_W = 48,
    parameter int unsigned DUR_W   = 8,
    parameter logic signed [SCORE_W-1:0] THRESH = SCORE_W'(1000)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      obs_we_i,
    input  logic [4:0]                obs_addr_i,
    input  logic signed [OBS_W-1:0]   obs_data_i,
    input  logic                      trans_we_i,
    input  logic [4:0]                trans_addr_i,
    input  logic                      trans_sel_i,
    input  logic signed [TRANS_W-1:0] trans_data_i,
    input  logic                      frame_valid_i,
    input  logic                      clear_i,
    output logic                      busy_o,
    output logic                      dv_o,
    output logic                      detect_o,
    output logic signed [SCORE_W-1:0] score_o,
    output logic [DUR_W-1:0]          duration_o,
    output logic                      overrun_o
);

    localparam int unsigned IdxW  = (STATES > 1) ? $clog2(STATES) : 1;
    // Two guard bits: delta + transition + observation cannot overflow before saturation.
    localparam int unsigned WideW = SCORE_W + 2;
    // Full-width signed(THRESH) x unsigned(dur) product.
    localparam int unsigned ProdW = SCORE_W + DUR_W + 1;

    localparam logic signed [SCORE_W-1:0] NegInf  = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic signed [SCORE_W-1:0] PosMax  = {1'b0, {(SCORE_W-1){1'b1}}};
    localparam logic [IdxW-1:0]           LastIdx = IdxW'(STATES - 1);
    localparam logic [DUR_W-1:0]          DurMax  = '1;

    typedef enum logic [1:0] {
        StIdle,
        StUpdate,
        StDecide
    } state_e;

    state_e                      state_q;
    logic [IdxW-1:0]             j_q;
    logic                        busy_q;
    logic                        dv_q;
    logic                        detect_q;
    logic signed [SCORE_W-1:0]   score_q;
    logic [DUR_W-1:0]            duration_q;
    logic                        overrun_q;

    logic signed [OBS_W-1:0]     obs_buf_q  [STATES];
    logic signed [OBS_W-1:0]     obs_work_q [STATES];
    logic signed [TRANS_W-1:0]   a_self_q   [STATES];
    logic signed [TRANS_W-1:0]   a_fwd_q    [STATES];
    logic signed [SCORE_W-1:0]   delta_q    [STATES];
    logic [DUR_W-1:0]            dur_q      [STATES];

    logic                        obs_addr_ok;
    logic                        trans_addr_ok;
    logic [IdxW-1:0]             obs_idx;
    logic [IdxW-1:0]             trans_idx;

    assign obs_addr_ok   = 32'(obs_addr_i) < STATES;
    assign trans_addr_ok = 32'(trans_addr_i) < STATES;
    assign obs_idx       = obs_addr_i[IdxW-1:0];
    assign trans_idx     = trans_addr_i[IdxW-1:0];

    // Per-state update for the state currently addressed by j_q.
    logic [IdxW-1:0]             j_prev;
    logic signed [SCORE_W-1:0]   cur_delta;
    logic signed [SCORE_W-1:0]   prev_delta;
    logic [DUR_W-1:0]            cur_dur;
    logic [DUR_W-1:0]            prev_dur;
    logic                        stay_ninf;
    logic                        fwd_ninf;
    logic signed [WideW-1:0]     stay_w;
    logic signed [WideW-1:0]     fwd_w;
    logic signed [WideW-1:0]     chosen_w;
    logic signed [WideW-1:0]     sum_w;
    logic                        take_stay;
    logic [DUR_W-1:0]            src_dur;
    logic signed [SCORE_W-1:0]   upd_delta;
    logic [DUR_W-1:0]            upd_dur;

    always_comb begin
        j_prev     = j_q - 1'b1;
        cur_delta  = delta_q[j_q];
        cur_dur    = dur_q[j_q];
        // State 0's predecessor is word entry: score 0, duration 0, never NEG_INF.
        if (j_q == '0) begin
            prev_delta = '0;
            prev_dur   = '0;
        end else begin
            prev_delta = delta_q[j_prev];
            prev_dur   = dur_q[j_prev];
        end
        stay_ninf  = (cur_delta == NegInf);
        fwd_ninf   = (j_q != '0) && (prev_delta == NegInf);
        stay_w     = WideW'(cur_delta) + WideW'(a_self_q[j_q]);
        fwd_w      = WideW'(prev_delta) + WideW'(a_fwd_q[j_q]);
        // Ties go to the self loop.
        take_stay  = !stay_ninf && (fwd_ninf || (stay_w >= fwd_w));
        chosen_w   = take_stay ? stay_w : fwd_w;
        src_dur    = take_stay ? cur_dur : prev_dur;
        sum_w      = chosen_w + WideW'(obs_work_q[j_q]);

        upd_delta  = NegInf;
        upd_dur    = '0;
        if (!(stay_ninf && fwd_ninf)) begin
            if (sum_w > WideW'(PosMax)) begin
                upd_delta = PosMax;
            end else if (sum_w < WideW'(NegInf)) begin
                upd_delta = NegInf;
            end else begin
                upd_delta = sum_w[SCORE_W-1:0];
            end
            upd_dur = (src_dur == DurMax) ? src_dur : src_dur + 1'b1;
        end
    end

    // Final-state decision: delta >= THRESH * dur without any divide.
    logic signed [SCORE_W-1:0]   last_delta;
    logic [DUR_W-1:0]            last_dur;
    logic signed [ProdW-1:0]     thresh_w;
    logic signed [ProdW-1:0]     dur_w;
    logic signed [ProdW-1:0]     prod_w;
    logic signed [ProdW-1:0]     delta_w;
    logic                        detect_d;

    always_comb begin
        last_delta = delta_q[LastIdx];
        last_dur   = dur_q[LastIdx];
        thresh_w   = ProdW'(THRESH);
        dur_w      = ProdW'({1'b0, last_dur});
        prod_w     = thresh_w * dur_w;
        delta_w    = ProdW'(last_delta);
        detect_d   = (last_delta != NegInf) && (delta_w >= prod_w);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            j_q        <= '0;
            busy_q     <= 1'b0;
            dv_q       <= 1'b0;
            detect_q   <= 1'b0;
            score_q    <= '0;
            duration_q <= '0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < STATES; i++) begin
                obs_buf_q[i]  <= '0;
                obs_work_q[i] <= '0;
                a_self_q[i]   <= '0;
                a_fwd_q[i]    <= '0;
                delta_q[i]    <= NegInf;
                dur_q[i]      <= '0;
            end
        end else begin
            dv_q <= 1'b0;

            // The host may preload the next frame's observations while busy.
            if (obs_we_i && obs_addr_ok) begin
                obs_buf_q[obs_idx] <= obs_data_i;
            end

            // The table is read throughout UPDATE, so it is frozen while busy.
            if (trans_we_i && trans_addr_ok && (state_q == StIdle)) begin
                if (trans_sel_i) begin
                    a_fwd_q[trans_idx] <= trans_data_i;
                end else begin
                    a_self_q[trans_idx] <= trans_data_i;
                end
            end

            case (state_q)
                StIdle: begin
                    if (clear_i) begin
                        for (int i = 0; i < STATES; i++) begin
                            delta_q[i] <= NegInf;
                            dur_q[i]   <= '0;
                        end
                        overrun_q <= 1'b0;
                    end else if (frame_valid_i) begin
                        obs_work_q <= obs_buf_q;
                        j_q        <= LastIdx;
                        busy_q     <= 1'b1;
                        state_q    <= StUpdate;
                    end
                end

                StUpdate: begin
                    // Descending j keeps delta[j-1] at its previous-frame value when read.
                    delta_q[j_q] <= upd_delta;
                    dur_q[j_q]   <= upd_dur;
                    if (frame_valid_i) begin
                        overrun_q <= 1'b1;
                    end
                    if (j_q == '0) begin
                        state_q <= StDecide;
                    end else begin
                        j_q <= j_q - 1'b1;
                    end
                end

                StDecide: begin
                    dv_q       <= 1'b1;
                    detect_q   <= detect_d;
                    score_q    <= last_delta;
                    duration_q <= last_dur;
                    busy_q     <= 1'b0;
                    state_q    <= StIdle;
                    if (frame_valid_i) begin
                        overrun_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign dv_o       = dv_q;
    assign detect_o   = detect_q;
    assign score_o    = score_q;
    assign duration_o = duration_q;
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_viterbi_lr_scorer.sv
// Testbench for viterbi_lr_scorer. Two instances share all stimulus: a default-width one
// (SCORE_W=48) and a narrow one (SCORE_W=34) that exercises score saturation. Both use
// THRESH=5. A frame-level model predicts every output on every cycle.
module tb_viterbi_lr_scorer;

    localparam int     S  = 5;
    localparam longint TH = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               obs_we = 1'b0;
    logic [4:0]         obs_addr = '0;
    logic signed [31:0] obs_data = '0;
    logic               trans_we = 1'b0;
    logic [4:0]         trans_addr = '0;
    logic               trans_sel = 1'b0;
    logic signed [15:0] trans_data = '0;
    logic               fv = 1'b0;
    logic               clr = 1'b0;

    logic               busy0, dv0, det0, ovr0;
    logic signed [47:0] score0;
    logic [7:0]         dur0;
    logic               busy1, dv1, det1, ovr1;
    logic signed [33:0] score1;
    logic [7:0]         dur1;

    always #5 clk = ~clk;

    viterbi_lr_scorer #(
        .STATES(5), .OBS_W(32), .TRANS_W(16), .SCORE_W(48), .DUR_W(8), .THRESH(48'sd5)
    ) dut0 (
        .clk(clk), .reset(rst_n),
        .obs_we_i(obs_we), .obs_addr_i(obs_addr), .obs_data_i(obs_data),
        .trans_we_i(trans_we), .trans_addr_i(trans_addr), .trans_sel_i(trans_sel),
        .trans_data_i(trans_data), .frame_valid_i(fv), .clear_i(clr),
        .busy_o(busy0), .dv_o(dv0), .detect_o(det0), .score_o(score0),
        .duration_o(dur0), .overrun_o(ovr0)
    );

    viterbi_lr_scorer #(
        .STATES(5), .OBS_W(32), .TRANS_W(16), .SCORE_W(34), .DUR_W(8), .THRESH(34'sd5)
    ) dut1 (
        .clk(clk), .reset(rst_n),
        .obs_we_i(obs_we), .obs_addr_i(obs_addr), .obs_data_i(obs_data),
        .trans_we_i(trans_we), .trans_addr_i(trans_addr), .trans_sel_i(trans_sel),
        .trans_data_i(trans_data), .frame_valid_i(fv), .clear_i(clr),
        .busy_o(busy1), .dv_o(dv1), .detect_o(det1), .score_o(score1),
        .duration_o(dur1), .overrun_o(ovr1)
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint md [2][S];
    int     mu [2][S];
    longint mself [S];
    longint mfwd [S];
    longint mobs [S];
    longint exp_score [2];
    int     exp_dur [2];
    bit     exp_det [2];
    bit     have;
    longint ecount, acc;
    bit     exp_busy, exp_dv, exp_ovr;

    function automatic int sw(int k);
        return (k == 0) ? 48 : 34;
    endfunction

    function automatic longint neg_inf(int k);
        return -(longint'(1) << (sw(k) - 1));
    endfunction

    function automatic longint pos_max(int k);
        return (longint'(1) << (sw(k) - 1)) - 1;
    endfunction

    // One whole frame of the Viterbi recursion, computed from the previous frame's scores.
    function automatic void model_frame(int k);
        longint od [S];
        int     ou [S];
        longint pred, best;
        int     pu, bu;
        bit     pred_ok, stay_ok;
        for (int i = 0; i < S; i++) begin
            od[i] = md[k][i];
            ou[i] = mu[k][i];
        end
        for (int j = 0; j < S; j++) begin
            if (j == 0) begin
                pred = 0; pu = 0; pred_ok = 1'b1;
            end else begin
                pred = od[j-1]; pu = ou[j-1]; pred_ok = (od[j-1] != neg_inf(k));
            end
            stay_ok = (od[j] != neg_inf(k));
            if (!stay_ok && !pred_ok) begin
                md[k][j] = neg_inf(k);
                mu[k][j] = 0;
            end else begin
                if (stay_ok && (!pred_ok || (od[j] + mself[j] >= pred + mfwd[j]))) begin
                    best = od[j] + mself[j]; bu = ou[j];
                end else begin
                    best = pred + mfwd[j]; bu = pu;
                end
                best = best + mobs[j];
                if (best > pos_max(k)) best = pos_max(k);
                if (best < neg_inf(k)) best = neg_inf(k);
                md[k][j] = best;
                mu[k][j] = (bu < 255) ? bu + 1 : 255;
            end
        end
        exp_score[k] = md[k][S-1];
        exp_dur[k]   = mu[k][S-1];
        exp_det[k]   = (md[k][S-1] != neg_inf(k)) && (md[k][S-1] >= TH * longint'(mu[k][S-1]));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < S; i++) begin
                md[k][i] = neg_inf(k);
                mu[k][i] = 0;
            end
        end
        for (int i = 0; i < S; i++) begin
            mself[i] = 0; mfwd[i] = 0; mobs[i] = 0;
        end
        have = 1'b0; ecount = 0; acc = 0;
        exp_busy = 1'b0; exp_dv = 1'b0; exp_ovr = 1'b0;
    endtask

    task automatic model_step();
        bit idle;
        ecount++;
        idle = !have || (ecount > acc + S + 1);
        if (trans_we && idle && (int'(trans_addr) < S)) begin
            if (trans_sel) mfwd[trans_addr] = longint'(trans_data);
            else           mself[trans_addr] = longint'(trans_data);
        end
        if (idle && clr) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < S; i++) begin
                    md[k][i] = neg_inf(k);
                    mu[k][i] = 0;
                end
            end
            exp_ovr = 1'b0;
        end else if (idle && fv) begin
            have = 1'b1;
            acc  = ecount;
            model_frame(0);
            model_frame(1);
        end else if (!idle && fv) begin
            exp_ovr = 1'b1;
        end
        // Buffer write lands after the accept snapshot of the same edge.
        if (obs_we && (int'(obs_addr) < S)) mobs[obs_addr] = longint'(obs_data);
        exp_busy = have && (ecount - acc < S + 1);
        exp_dv   = have && (ecount - acc == S + 1);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("busy0", longint'(busy0), longint'(exp_busy));
                chk("busy1", longint'(busy1), longint'(exp_busy));
                chk("dv0", longint'(dv0), longint'(exp_dv));
                chk("dv1", longint'(dv1), longint'(exp_dv));
                chk("overrun0", longint'(ovr0), longint'(exp_ovr));
                chk("overrun1", longint'(ovr1), longint'(exp_ovr));
                if (exp_dv) begin
                    chk("score0", longint'(score0), exp_score[0]);
                    chk("duration0", longint'(dur0), longint'(exp_dur[0]));
                    chk("detect0", longint'(det0), longint'(exp_det[0]));
                    chk("score1", longint'(score1), exp_score[1]);
                    chk("duration1", longint'(dur1), longint'(exp_dur[1]));
                    chk("detect1", longint'(det1), longint'(exp_det[1]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    longint r_score0, r_score1;
    int     r_dur0;
    bit     r_det0;
    bit     rnd_mode = 1'b0;
    longint neg48 = -(longint'(1) << 47);

    task automatic set_all_obs(input longint v);
        for (int a = 0; a < S; a++) begin
            @(negedge clk);
            obs_we = 1'b1; obs_addr = 5'(a); obs_data = 32'(v);
        end
        @(negedge clk);
        obs_we = 1'b0;
    endtask

    task automatic set_trans(input int a, input bit sel, input int v);
        @(negedge clk);
        trans_we = 1'b1; trans_addr = 5'(a); trans_sel = sel; trans_data = 16'(v);
        @(negedge clk);
        trans_we = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Start a frame; optionally re-pulse frame_valid on loop step pulse_at (0 = 2nd UPDATE cycle).
    task automatic run_frame(input int pulse_at);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        fv = 1'b1;
        @(negedge clk);
        fv = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (dv0) begin
                seen = 1'b1;
                r_score0 = longint'(score0); r_dur0 = int'(dur0); r_det0 = det0;
                r_score1 = longint'(score1);
            end else begin
                fv = (i == pulse_at);
                if (rnd_mode) begin
                    obs_we = ($urandom_range(2) == 0);
                    obs_addr = 5'($urandom_range(6));
                    obs_data = 32'(int'($urandom_range(200)) - 50);
                    trans_we = ($urandom_range(4) == 0);
                    trans_addr = 5'($urandom_range(6));
                    trans_sel = 1'($urandom_range(1));
                    trans_data = 16'(int'($urandom_range(120)) - 60);
                end
            end
        end
        fv = 1'b0; obs_we = 1'b0; trans_we = 1'b0;
        if (!seen) begin
            n_checks++;
            n_err++;
            $display("FAIL dv_timeout: got no dv, expected dv within 20 cycles");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", longint'(busy0), 0);
        chk("reset_dv", longint'(dv0), 0);
        chk("reset_detect", longint'(det0), 0);
        chk("reset_overrun", longint'(ovr0), 0);
        chk("reset_score", longint'(score0), 0);
        chk("reset_duration", longint'(dur0), 0);

        // Observations 10, zero transitions: state 4 becomes reachable on frame 5.
        set_all_obs(10);
        for (int f = 1; f <= 5; f++) begin
            run_frame(99);
            if (f == 1) begin
                chk("s1_f1_score", r_score0, neg48);
                chk("s1_f1_detect", longint'(r_det0), 0);
            end
        end
        chk("s1_f5_score", r_score0, 50);
        chk("s1_f5_duration", longint'(r_dur0), 5);
        chk("s1_f5_detect", longint'(r_det0), 1);

        // Observations 3: 15 < 5*5.
        do_clear();
        set_all_obs(3);
        for (int f = 1; f <= 5; f++) run_frame(99);
        chk("s2_f5_score", r_score0, 15);
        chk("s2_f5_duration", longint'(r_dur0), 5);
        chk("s2_f5_detect", longint'(r_det0), 0);

        // Penalised self loop at state 2 forces the forward path there.
        do_clear();
        set_all_obs(10);
        set_trans(2, 1'b0, -100);
        for (int f = 1; f <= 6; f++) begin
            run_frame(99);
            if (f == 5) chk("s3_f5_score", r_score0, 50);
        end
        chk("s3_f6_score", r_score0, 60);
        chk("s3_f6_duration", longint'(r_dur0), 6);
        set_trans(2, 1'b0, 0);

        // Extra frame_valid during UPDATE: overrun only, results unchanged.
        do_clear();
        run_frame(0);
        chk("s4_overrun_set", longint'(ovr0), 1);
        for (int f = 2; f <= 5; f++) run_frame(99);
        chk("s4_f5_score", r_score0, 50);
        chk("s4_f5_duration", longint'(r_dur0), 5);
        do_clear();
        chk("s4_overrun_clr", longint'(ovr0), 0);
        run_frame(99);
        chk("s4_clear_score", r_score0, neg48);

        // Saturation of the narrow instance.
        do_clear();
        set_all_obs(2147483647);
        for (int f = 1; f <= 8; f++) run_frame(99);
        chk("s5_sat_score34", r_score1, 64'sd8589934591);
        chk("s5_score48", r_score0, 64'sd17179869176);

        // Reset in the middle of UPDATE.
        @(negedge clk);
        fv = 1'b1;
        @(negedge clk);
        fv = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_busy", longint'(busy0), 0);
        chk("s6_rst_score", longint'(score0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_all_obs(10);
        for (int f = 1; f <= 5; f++) begin
            run_frame(99);
            if (f == 1) chk("s6_f1_score", r_score0, neg48);
        end
        chk("s6_f5_score", r_score0, 50);
        chk("s6_f5_duration", longint'(r_dur0), 5);
        chk("s6_f5_detect", longint'(r_det0), 1);

        // Randomised traffic checked by the model.
        rnd_mode = 1'b1;
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(9) == 0) do_clear();
            if ($urandom_range(2) == 0) begin
                set_trans(int'($urandom_range(6)), 1'($urandom_range(1)),
                          int'($urandom_range(120)) - 60);
            end
            repeat ($urandom_range(2)) begin
                @(negedge clk);
                obs_we = 1'b1;
                obs_addr = 5'($urandom_range(6));
                obs_data = 32'(int'($urandom_range(200)) - 50);
            end
            @(negedge clk);
            obs_we = 1'b0;
            run_frame(int'($urandom_range(9)));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/viterbi_lr_scorer.md
Name: viterbi_lr_scorer

Overview:
Parametrised left-to-right HMM Viterbi word-spotting scorer; successor to the fixed 5-state scorer.
Per frame it updates STATES log-domain path scores from loaded observation scores and a runtime-loadable transition table.
It tracks each state's path duration and flags a detection when the final-state score clears a per-frame threshold scaled by duration, with no divide table.
It sits behind the feature/observation front end; one instance per HMM.

Parameters:
STATES, 5, number of HMM states (2..32)
OBS_W, 32, signed observation score width b(t,j)
TRANS_W, 16, signed log transition width
SCORE_W, 48, signed path-score width (SCORE_W > OBS_W)
DUR_W, 8, duration counter width
THRESH, 1000, signed per-frame detection threshold (SCORE_W bits)

Ports:
clk  in  1  clock
reset  in  1  reset
obs_we  in  1  write observation buffer
obs_addr  in  5  state index for obs_data
obs_data  in  OBS_W  signed b(t,j)
trans_we  in  1  write transition table
trans_addr  in  5  destination state j
trans_sel  in  1  0 = self a(j,j), 1 = forward a(j-1,j)
trans_data  in  TRANS_W  signed log transition
frame_valid  in  1  observation buffer complete; process frame
clear  in  1  restart search (idle only)
busy  out  1  frame in progress
dv  out  1  one-cycle result strobe
detect  out  1  detection result, valid with dv
score  out  SCORE_W  final-state delta, valid with dv
duration  out  DUR_W  final-state path length in frames, valid with dv
overrun  out  1  sticky: frame_valid arrived while busy

Behaviour:
- Interface: reset reset, asynchronous, active-low; clock clk.
- Reset:
  - busy, dv, detect, overrun = 0; score = 0; duration = 0.
  - All delta[j] = NEG_INF, the minimum SCORE_W value.
  - All dur[j] = 0; transition table = 0; observation buffers = 0.
- Observation buffer: writes are accepted in any state. obs_addr >= STATES is ignored.
- Working observation set: copied from the buffer on the frame_valid accept edge, so the next frame can load while busy.
- Transition writes: accepted only when busy = 0; ignored while busy. trans_sel = 1 with j = 0 sets the entry penalty.
- clear: with busy = 0, resets delta to NEG_INF, dur to 0 and overrun to 0 next cycle. Ignored while busy.
- clear and frame_valid in the same idle cycle: clear wins; the frame is dropped.
- FSM states: IDLE -> UPDATE -> DECIDE -> IDLE.
  - IDLE: frame_valid = 1 -> busy = 1, j = STATES-1, go to UPDATE.
  - frame_valid while busy: ignored; overrun set.
- UPDATE: one state per cycle, j descending, in place, so delta[j-1] still holds frame t-1 when read.
  - stay = delta[j] + a(j,j)
  - fwd = delta[j-1] + a(j-1,j); for j = 0 the predecessor score is 0, allowing word entry at any frame.
  - Any candidate built from NEG_INF stays NEG_INF.
  - Choose stay if stay >= fwd (tie prefers self).
  - delta[j] = chosen + b(j), saturating at the SCORE_W signed limits; a NEG_INF choice gives NEG_INF.
  - dur[j] = dur of chosen source + 1, saturating at 2^DUR_W - 1; entry source dur = 0. NEG_INF choice gives dur 0.
  - After j = 0, go to DECIDE.
- DECIDE (1 cycle): detect = (delta[STATES-1] != NEG_INF) and (delta[STATES-1] >= THRESH * dur[STATES-1]).
  - The product is full width, signed by unsigned.
  - Drive score and duration; dv = 1 for exactly this one cycle; busy = 0 on the next cycle.
- Latency: frame_valid accept edge -> dv after STATES+1 cycles. Throughput is one frame per STATES+2 cycles.
- detect has no side effect on delta; resetting search state is done by the host via clear.
- Reset asserted mid-frame: immediate return to IDLE with reset values; the partial frame is discarded.
- Out-of-range trans_addr is ignored.

Test Plan:
- Default params, transitions 0, all obs = 10, 5 frames: dv for frames 1-4 with detect = 0 and score = NEG_INF. Frame 5 gives score = 50, duration = 5, detect = 1 (50 >= 25).
- Same setup, obs = 3 for all states: frame 5 gives score = 15, duration = 5, detect = 0 (15 < 25).
- a(2,2) = -100, all other transitions 0, obs = 10: check the forward path is chosen at state 2. Tie with equal candidates selects self, confirmed via the duration value.
- frame_valid pulsed on cycle 2 of UPDATE: overrun = 1, frame count unchanged, results identical to the no-pulse run. clear in idle resets overrun and scores.
- obs_data = 2^31-1 repeated with SCORE_W = 34: delta saturates at 2^33-1, no wrap to negative.
- reset deasserted then reasserted during UPDATE: busy = 0 and deltas = NEG_INF at once. The next frame behaves as frame 1 of the first scenario.
